// File: rtl/ant_navigator.sv
// Wall-following ant controller: WAIT -> RUN -> DONE, one registered move per cycle.
// Optional pheromone marking/avoidance is compiled in with `define PHEROMONE_EN.
module ant_navigator #(
  parameter int START_DELAY = 2,
  parameter int STEP_W      = 8,
  parameter int MAX_STEPS   = 200,
  parameter int PH_WIDTH    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ant_r,
  input  logic              ant_l,
  input  logic              hit,
  input  logic              escape,
  output logic [1:0]        move,
  output logic              done,
  output logic              timeout,
  output logic [STEP_W-1:0] step_cnt
`ifdef PHEROMONE_EN
  ,
  output logic [PH_WIDTH-1:0] ph_drop,
  input  logic [PH_WIDTH-1:0] ph_detected
`endif
);

  localparam logic [1:0] ST_WAIT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [1:0] MV_HALT  = 2'b00;
  localparam logic [1:0] MV_RIGHT = 2'b01;
  localparam logic [1:0] MV_LEFT  = 2'b10;
  localparam logic [1:0] MV_FWD   = 2'b11;

  localparam logic [STEP_W-1:0] STEP_LIMIT = STEP_W'(MAX_STEPS);
  localparam logic [STEP_W-1:0] STEP_SAT   = '1;
  localparam logic [4:0]        DELAY_END  = 5'(START_DELAY);

  logic [1:0]        state_q, state_d;
  logic [3:0]        delay_q, delay_d;
  logic [1:0]        move_q, move_d;
  logic              done_q, done_d;
  logic              timeout_q, timeout_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic              turned_r_q, turned_r_d;
  logic [1:0]        left_cnt_q, left_cnt_d;

  logic [PH_WIDTH-1:0] ph_det;
  logic                ph_block;
  logic                at_limit;
  logic                run_go;
  logic [1:0]          nxt_move;

`ifdef PHEROMONE_EN
  assign ph_det = ph_detected;
`else
  assign ph_det = '0;
`endif

  // A visited cell suppresses the right-turn preference.
  assign ph_block = |ph_det;
  assign at_limit = (step_q == STEP_LIMIT);
  assign run_go   = (state_q == ST_RUN) && !escape && !at_limit;

  always_comb begin
    nxt_move = MV_FWD;
    if (turned_r_q) begin
      nxt_move = hit ? MV_LEFT : MV_FWD;
    end else if (!ant_r && !ph_block) begin
      nxt_move = MV_RIGHT;
    end else if (hit) begin
      nxt_move = MV_LEFT;
    end
    // Cornered after three LEFTs: another LEFT only while the wall is still ahead.
    if (nxt_move == MV_LEFT && left_cnt_q == 2'd3 && ant_l && !hit) begin
      nxt_move = MV_FWD;
    end
  end

  always_comb begin
    state_d    = state_q;
    delay_d    = delay_q;
    move_d     = MV_HALT;
    done_d     = done_q;
    timeout_d  = timeout_q;
    step_d     = step_q;
    turned_r_d = turned_r_q;
    left_cnt_d = left_cnt_q;
    case (state_q)
      ST_WAIT: begin
        delay_d = delay_q + 4'd1;
        if ({1'b0, delay_q} + 5'd1 >= DELAY_END) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (escape) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else if (at_limit) begin
          state_d   = ST_DONE;
          done_d    = 1'b1;
          timeout_d = 1'b1;
        end else begin
          move_d     = nxt_move;
          turned_r_d = (nxt_move == MV_RIGHT);
          if (nxt_move == MV_LEFT) begin
            left_cnt_d = (left_cnt_q == 2'd3) ? 2'd3 : left_cnt_q + 2'd1;
          end else begin
            left_cnt_d = 2'd0;
          end
          step_d = (step_q == STEP_SAT) ? step_q : step_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_WAIT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_WAIT;
      delay_q    <= '0;
      move_q     <= MV_HALT;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
      step_q     <= '0;
      turned_r_q <= 1'b0;
      left_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      delay_q    <= delay_d;
      move_q     <= move_d;
      done_q     <= done_d;
      timeout_q  <= timeout_d;
      step_q     <= step_d;
      turned_r_q <= turned_r_d;
      left_cnt_q <= left_cnt_d;
    end
  end

`ifdef PHEROMONE_EN
  logic [PH_WIDTH-1:0] ph_drop_q, ph_drop_d;

  // Mark a fresh cell whenever we advance into it unvisited.
  always_comb begin
    ph_drop_d = '0;
    if (run_go && nxt_move == MV_FWD && ph_det == '0) begin
      ph_drop_d = PH_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ph_drop_q <= '0;
    end else begin
      ph_drop_q <= ph_drop_d;
    end
  end

  assign ph_drop = ph_drop_q;
`endif

  assign move     = move_q;
  assign done     = done_q;
  assign timeout  = timeout_q;
  assign step_cnt = step_q;

endmodule

// File: tb/tb_ant_navigator.sv
// Directed bench for ant_navigator (START_DELAY=2, MAX_STEPS=5).
module tb_ant_navigator;

  localparam logic [1:0] HALT  = 2'b00;
  localparam logic [1:0] RIGHT = 2'b01;
  localparam logic [1:0] LEFT  = 2'b10;
  localparam logic [1:0] FWD   = 2'b11;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ant_r = 1'b0;
  logic       ant_l = 1'b0;
  logic       hit = 1'b0;
  logic       escape = 1'b0;
  logic [1:0] move;
  logic       done;
  logic       timeout;
  logic [7:0] step_cnt;
`ifdef PHEROMONE_EN
  logic [1:0] ph_drop;
  logic [1:0] ph_detected = 2'b00;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  ant_navigator #(
    .START_DELAY(2),
    .STEP_W(8),
    .MAX_STEPS(5),
    .PH_WIDTH(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ant_r(ant_r),
    .ant_l(ant_l),
    .hit(hit),
    .escape(escape),
    .move(move),
    .done(done),
    .timeout(timeout),
    .step_cnt(step_cnt)
`ifdef PHEROMONE_EN
    ,
    .ph_drop(ph_drop),
    .ph_detected(ph_detected)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic [1:0] mv, input logic dn,
                      input logic to, input logic [7:0] cnt);
    chk({tag, ".move"}, 16'(move), 16'(mv));
    chk({tag, ".done"}, 16'(done), 16'(dn));
    chk({tag, ".timeout"}, 16'(timeout), 16'(to));
    chk({tag, ".step_cnt"}, 16'(step_cnt), 16'(cnt));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    escape = 1'b0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    // Reset and start-up delay, then straight corridor.
    ant_r = 1'b1;
    step();
    chk4("reset", HALT, 1'b0, 1'b0, 8'd0);
`ifdef PHEROMONE_EN
    chk("reset.ph_drop", 16'(ph_drop), 16'd0);
`endif
    rst = 1'b0;
    step(); chk4("wait1", HALT, 1'b0, 1'b0, 8'd0);
    step(); chk4("wait2", HALT, 1'b0, 1'b0, 8'd0);
    step(); chk4("fwd1", FWD, 1'b0, 1'b0, 8'd1);
    step(); chk4("fwd2", FWD, 1'b0, 1'b0, 8'd2);

    // Open on the right: RIGHT then forced FORWARD.
    ant_r = 1'b0;
    step(); chk4("alt_r", RIGHT, 1'b0, 1'b0, 8'd3);
    step(); chk4("alt_f", FWD, 1'b0, 1'b0, 8'd4);
    ant_r = 1'b0;
    step(); chk4("alt_r2", RIGHT, 1'b0, 1'b0, 8'd5);

    // Budget exhausted: timeout, then sensors ignored.
    step(); chk4("timeout", HALT, 1'b1, 1'b1, 8'd5);
    escape = 1'b1; hit = 1'b1;
    step(); chk4("done_hold", HALT, 1'b1, 1'b1, 8'd5);

    // Reset pulsed in DONE restarts the wait; five FORWARDs then timeout.
    hit = 1'b0; ant_r = 1'b1;
    do_reset();
    chk4("rst_done", HALT, 1'b0, 1'b0, 8'd0);
    step(); chk4("rwait1", HALT, 1'b0, 1'b0, 8'd0);
    step(); chk4("rwait2", HALT, 1'b0, 1'b0, 8'd0);
    for (int i = 1; i <= 5; i++) begin
      step(); chk4("max_fwd", FWD, 1'b0, 1'b0, 8'(i));
    end
    step(); chk4("max_to", HALT, 1'b1, 1'b1, 8'd5);
    step(); chk4("max_hold", HALT, 1'b1, 1'b1, 8'd5);

    // Escape on the same cycle as the budget limit: escape wins.
    do_reset();
    step(); step();
    for (int i = 1; i <= 5; i++) begin
      step(); chk4("esc_fwd", FWD, 1'b0, 1'b0, 8'(i));
    end
    escape = 1'b1;
    step(); chk4("esc_win", HALT, 1'b1, 1'b0, 8'd5);
    escape = 1'b0; ant_r = 1'b0;
    step(); chk4("esc_hold", HALT, 1'b1, 1'b0, 8'd5);

    // Right turn into a wall, then plain wall ahead, then escape mid-run.
    do_reset();
    step(); step();
    ant_r = 1'b0; hit = 1'b0;
    step(); chk4("turn_r", RIGHT, 1'b0, 1'b0, 8'd1);
    hit = 1'b1;
    step(); chk4("turn_hit", LEFT, 1'b0, 1'b0, 8'd2);
    ant_r = 1'b1; ant_l = 1'b1;
    step(); chk4("wall_l", LEFT, 1'b0, 1'b0, 8'd3);
    escape = 1'b1;
    step(); chk4("esc_mid", HALT, 1'b1, 1'b0, 8'd3);

`ifdef PHEROMONE_EN
    // Visited cell blocks the right turn; fresh cells get marked.
    hit = 1'b0; ant_l = 1'b0;
    do_reset();
    step(); step();
    ant_r = 1'b0; ph_detected = 2'b01;
    step(); chk4("ph_fwd", FWD, 1'b0, 1'b0, 8'd1);
    chk("ph_fwd.ph_drop", 16'(ph_drop), 16'd0);
    ph_detected = 2'b00;
    step(); chk4("ph_right", RIGHT, 1'b0, 1'b0, 8'd2);
    chk("ph_right.ph_drop", 16'(ph_drop), 16'd0);
    step(); chk4("ph_mark", FWD, 1'b0, 1'b0, 8'd3);
    chk("ph_mark.ph_drop", 16'(ph_drop), 16'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
